beep_melody_seq: RTL and testbench

Melody sequencer that sits directly upstream of the buzzer driver stage. On a start pulse it steps through a fixed 8-entry note table. For each entry it presents a tone half-period divider value and a tone enable to the downstream square-wave/buzzer stage, and it inserts a short silent gap between notes. It ends on completion, or loops continuously while loop mode is set.

---
 rtl/beep_melody_seq.sv | 170 +++++++++++++++++
 tb/tb_beep_melody_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/beep_melody_seq.sv
`default_nettype none
// ============================================================================
//  Module   : beep_melody_seq
//  Purpose  : Steps through a fixed 8-note table, presenting a tone divider
//             and enable to the buzzer driver with a silent gap after each note.
//  Revision : 1.0 - initial release
// ============================================================================
module beep_melody_seq #(
    parameter int unsigned NOTE_TICKS = 32'd12_500_000,
    parameter int unsigned GAP_TICKS  = 32'd500_000
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    output logic [16:0] note_div,
    output logic        note_en,
    output logic [2:0]  note_idx,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0]  c_st_idle = 2'd0;
    localparam logic [1:0]  c_st_tone = 2'd1;
    localparam logic [1:0]  c_st_gap  = 2'd2;

    localparam logic [31:0] c_tone1_last = 32'(NOTE_TICKS - 1);
    localparam logic [31:0] c_tone2_last = 32'(2 * NOTE_TICKS - 1);
    localparam logic [31:0] c_gap_last   = 32'(GAP_TICKS - 1);
    localparam logic [2:0]  c_last_idx   = 3'd7;

    // Half-period counts at 50 MHz; zero marks the REST entry.
    function automatic logic [16:0] f_div(input logic [2:0] idx);
        logic [16:0] v;
        case (idx)
            3'd0:    v = 17'd95420;
            3'd1:    v = 17'd85034;
            3'd2:    v = 17'd75758;
            3'd3:    v = 17'd71633;
            3'd4:    v = 17'd63776;
            3'd5:    v = 17'd56818;
            3'd6:    v = 17'd50607;
            default: v = 17'd0;
        endcase
        return v;
    endfunction

    logic [1:0]  r_state, w_state;
    logic [2:0]  r_idx,   w_idx;
    logic [31:0] r_cnt,   w_cnt;
    logic [16:0] r_div,   w_div;
    logic        r_en,    w_en;
    logic        r_busy,  w_busy;
    logic        r_done,  w_done;

    logic [31:0] w_term;
    logic        w_last;
    logic        w_load;
    logic [2:0]  w_load_idx;
    logic [16:0] w_load_div;

    // Only entry 4 (G) is a two-unit note.
    assign w_term = (r_state == c_st_gap) ? c_gap_last :
                    ((r_idx == 3'd4) ? c_tone2_last : c_tone1_last);
    assign w_last = (r_cnt == w_term);

    always_comb begin
        w_state    = r_state;
        w_idx      = r_idx;
        w_cnt      = r_cnt + 32'd1;
        w_div      = r_div;
        w_en       = r_en;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_load     = 1'b0;
        w_load_idx = 3'd0;
        w_load_div = 17'd0;

        if (stop) begin
            w_state = c_st_idle;
            w_idx   = 3'd0;
            w_cnt   = 32'd0;
            w_div   = 17'd0;
            w_en    = 1'b0;
            w_busy  = 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    w_cnt = 32'd0;
                    if (start) begin
                        w_load     = 1'b1;
                        w_load_idx = 3'd0;
                    end
                end
                c_st_tone: begin
                    if (w_last) begin
                        w_state = c_st_gap;
                        w_en    = 1'b0;
                        w_cnt   = 32'd0;
                    end
                end
                c_st_gap: begin
                    if (w_last) begin
                        if (r_idx != c_last_idx) begin
                            w_load     = 1'b1;
                            w_load_idx = r_idx + 3'd1;
                        end else if (loop_en) begin
                            w_load     = 1'b1;
                            w_load_idx = 3'd0;
                        end else begin
                            w_state = c_st_idle;
                            w_idx   = 3'd0;
                            w_cnt   = 32'd0;
                            w_div   = 17'd0;
                            w_busy  = 1'b0;
                            w_done  = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state = c_st_idle;
                    w_idx   = 3'd0;
                    w_cnt   = 32'd0;
                    w_div   = 17'd0;
                    w_en    = 1'b0;
                    w_busy  = 1'b0;
                end
            endcase

            if (w_load) begin
                w_load_div = f_div(w_load_idx);
                w_state    = c_st_tone;
                w_idx      = w_load_idx;
                w_cnt      = 32'd0;
                w_div      = w_load_div;
                w_en       = (w_load_div != 17'd0);
                w_busy     = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_idx   <= 3'd0;
            r_cnt   <= 32'd0;
            r_div   <= 17'd0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_cnt   <= w_cnt;
            r_div   <= w_div;
            r_en    <= w_en;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    assign note_div = r_div;
    assign note_en  = r_en;
    assign note_idx = r_idx;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_beep_melody_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_beep_melody_seq
//  Purpose  : Randomized and directed bench for beep_melody_seq against a
//             slot-position reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_beep_melody_seq;

    localparam int NT = 4;
    localparam int GT = 2;

    logic        sys_clk = 1'b0;
    logic        rst     = 1'b1;
    logic        start   = 1'b0;
    logic        stop    = 1'b0;
    logic        loop_en = 1'b0;
    logic [16:0] note_div;
    logic        note_en;
    logic [2:0]  note_idx;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    int div_tab [8] = '{95420, 85034, 75758, 71633, 63776, 56818, 50607, 0};
    int len_tab [8] = '{1, 1, 1, 1, 2, 1, 1, 1};

    // Model: position inside the current note slot (tone then gap).
    bit m_active = 0;
    bit m_done   = 0;
    int m_idx    = 0;
    int m_pos    = 0;

    beep_melody_seq #(.NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .note_div (note_div),
        .note_en  (note_en),
        .note_idx (note_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst || stop) begin
            m_active = 0; m_done = 0; m_idx = 0; m_pos = 0;
        end else if (!m_active) begin
            m_done = 0;
            if (start) begin
                m_active = 1; m_idx = 0; m_pos = 0;
            end
        end else begin
            m_done = 0;
            m_pos++;
            if (m_pos == len_tab[m_idx] * NT + GT) begin
                m_pos = 0;
                if (m_idx < 7) m_idx++;
                else if (loop_en) m_idx = 0;
                else begin
                    m_active = 0; m_done = 1; m_idx = 0;
                end
            end
        end
    endtask

    task automatic tick();
        int e_div;
        bit e_en;
        @(posedge sys_clk);
        model_step();
        #1;
        e_div = m_active ? div_tab[m_idx] : 0;
        e_en  = m_active && (m_pos < len_tab[m_idx] * NT) && (div_tab[m_idx] != 0);
        check("note_div", 32'(note_div), 32'(e_div));
        check("note_en",  32'(note_en),  32'(e_en));
        check("busy",     32'(busy),     32'(m_active));
        check("done",     32'(done),     32'(m_done));
        if (m_active) check("note_idx", 32'(note_idx), 32'(m_idx));
    endtask

    task automatic wait_at(input int idx, input int pos, input string tag);
        int n = 0;
        while (!(m_active && m_idx == idx && m_pos == pos) && n < 200) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 200), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int busy_cnt, done_at, done_cnt, busy_low, n;
        int divs[$];
        int prev_idx;
        bit prev_busy;

        // Reset, then idle with no start.
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();

        // Single pass: busy span, done offset and divider sequence.
        pulse_start();
        check("busy_first", 32'(busy), 32'd1);
        busy_cnt = 1; done_at = -1; prev_busy = 1; prev_idx = 0;
        divs.push_back(int'(note_div));
        for (int i = 2; i <= 60; i++) begin
            tick();
            if (busy) busy_cnt++;
            if (done) done_at = i;
            if (busy && (!prev_busy || int'(note_idx) != prev_idx)) divs.push_back(int'(note_div));
            prev_busy = busy;
            prev_idx  = int'(note_idx);
        end
        check("busy_span", 32'(busy_cnt), 32'd52);
        check("done_at",   32'(done_at),  32'd53);
        check("div_count", 32'(divs.size()), 32'd8);
        for (int i = 0; i < 8 && i < divs.size(); i++)
            check("div_seq", 32'(divs[i]), 32'(div_tab[i]));

        // Loop mode: three passes with no done and no busy drop.
        loop_en = 1'b1;
        pulse_start();
        done_cnt = 0; busy_low = 0;
        for (int i = 0; i < 3 * 52; i++) begin
            tick();
            if (done) done_cnt++;
            if (!busy) busy_low++;
        end
        check("loop_done", 32'(done_cnt), 32'd0);
        check("loop_busy", 32'(busy_low), 32'd0);
        check("loop_wrap_idx", 32'(note_idx), 32'd0);
        repeat (20) tick();
        loop_en = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check("loop_exit_done", 32'(done), 32'd1);
        repeat (3) tick();

        // Stop in the 2nd cycle of entry 3, then restart from entry 0.
        pulse_start();
        wait_at(3, 1, "reach_e3");
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_busy", 32'(busy), 32'd0);
        repeat (4) tick();
        pulse_start();
        check("restart_div", 32'(note_div), 32'd95420);
        repeat (60) tick();

        // Start+stop together in IDLE; start during entry 2.
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("collide_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        pulse_start();
        wait_at(2, 1, "reach_e2");
        pulse_start();
        repeat (60) tick();

        // Reset during the gap of entry 5, then a normal pass.
        pulse_start();
        wait_at(5, 4, "reach_e5_gap");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        pulse_start();
        repeat (60) tick();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom % 16) == 0;
            stop  = ($urandom % 80) == 0;
            rst   = ($urandom % 300) == 0;
            if (($urandom % 150) == 0) loop_en = ~loop_en;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
